// File: rtl/im_arbiter_if.sv
// ---------------------------------------------------------------------------
// im_arbiter_if
//
// Purpose : bundles the fetch port, the loader port and the instruction-memory
//           port of the instruction-memory arbiter into one interface.
//
// Modports
//   master : requester / memory side. Drives the requests, addresses, loader
//            write data and the memory read data. Observes grants, completions
//            and the memory address / write controls.
//   slave  : the arbiter itself (im_arbiter). Mirror image of master.
//
// Signals
//   f_req    1   fetch read request, held until f_gnt
//   f_addr   10  fetch word address
//   f_gnt    1   fetch request accepted this cycle
//   f_rvalid 1   fetch completion pulse
//   f_rdata  32  fetch read data (registered)
//   l_req    1   loader request, held until l_gnt
//   l_we     1   loader access type (1 write, 0 read)
//   l_addr   10  loader word address
//   l_wdata  32  loader write data
//   l_gnt    1   loader request accepted this cycle
//   l_rvalid 1   loader completion pulse (reads and writes)
//   l_rdata  32  loader read data, or the data written (registered)
//   im_addr  10  word address to the instruction memory
//   im_we    1   instruction-memory write enable
//   im_wdata 32  instruction-memory write data
//   im_rdata 32  combinational read data from the instruction memory
// ---------------------------------------------------------------------------
interface im_arbiter_if;
  logic        f_req;
  logic [9:0]  f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;

  logic        l_req;
  logic        l_we;
  logic [9:0]  l_addr;
  logic [31:0] l_wdata;
  logic        l_gnt;
  logic        l_rvalid;
  logic [31:0] l_rdata;

  logic [9:0]  im_addr;
  logic        im_we;
  logic [31:0] im_wdata;
  logic [31:0] im_rdata;

  modport master (
    output f_req, f_addr,
    output l_req, l_we, l_addr, l_wdata,
    output im_rdata,
    input  f_gnt, f_rvalid, f_rdata,
    input  l_gnt, l_rvalid, l_rdata,
    input  im_addr, im_we, im_wdata
  );

  modport slave (
    input  f_req, f_addr,
    input  l_req, l_we, l_addr, l_wdata,
    input  im_rdata,
    output f_gnt, f_rvalid, f_rdata,
    output l_gnt, l_rvalid, l_rdata,
    output im_addr, im_we, im_wdata
  );
endinterface

// File: rtl/im_arbiter.sv
// ---------------------------------------------------------------------------
// im_arbiter
//
// Purpose : shares one single-port instruction memory between a fetch port
//           (read only) and a loader port (read/write). One access is granted
//           per cycle; the grant is combinational, the memory read data (or
//           the loader write data) is captured at the end of the grant cycle
//           and reported with a one-cycle rvalid pulse in the next cycle.
//
// Ports
//   clk    in  sole clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of im_arbiter_if (fetch, loader and memory ports)
//
// Configuration
//   IM_ARB_RR_EN  defined   : contention resolved round-robin; the port not
//                             granted most recently wins. The last-grant
//                             pointer resets to "fetch", so the first
//                             contention goes to the loader.
//                 undefined : the loader always wins contention; no pointer.
// ---------------------------------------------------------------------------
module im_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  im_arbiter_if.slave  bus
);

  // Winner before reset gating, and the gated grants actually issued.
  logic w_l_win;
  logic w_f_win;
  logic w_l_gnt;
  logic w_f_gnt;

  // Completion registers.
  logic        r_f_rvalid;
  logic [31:0] r_f_rdata;
  logic        r_l_rvalid;
  logic [31:0] r_l_rdata;

`ifdef IM_ARB_RR_EN
  // 1: the loader was granted most recently; 0: the fetch port was.
  logic r_last_l;
`endif

  // Arbitration decision between the two requesters.
  always_comb begin
    w_l_win = 1'b0;
    w_f_win = 1'b0;
`ifdef IM_ARB_RR_EN
    if (bus.l_req && bus.f_req) begin
      // Contention: the port that did not win last time goes now.
      w_l_win = ~r_last_l;
      w_f_win = r_last_l;
    end else begin
      w_l_win = bus.l_req;
      w_f_win = bus.f_req;
    end
`else
    if (bus.l_req) begin
      w_l_win = 1'b1;
      w_f_win = 1'b0;
    end else begin
      w_l_win = 1'b0;
      w_f_win = bus.f_req;
    end
`endif
  end

  // No grant may be issued while reset is asserted; gating here also keeps
  // im_we low and lets im_addr fall back to the fetch address.
  assign w_l_gnt = w_l_win & rst_n;
  assign w_f_gnt = w_f_win & rst_n;

  assign bus.l_gnt    = w_l_gnt;
  assign bus.f_gnt    = w_f_gnt;
  assign bus.im_addr  = w_l_gnt ? bus.l_addr : bus.f_addr;
  assign bus.im_we    = w_l_gnt & bus.l_we;
  assign bus.im_wdata = bus.l_wdata;

  // Capture completion data at the end of each grant cycle; rdata holds
  // until that port's next completion. Async reset cancels a pending pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f_rvalid <= 1'b0;
      r_f_rdata  <= 32'h0000_0000;
      r_l_rvalid <= 1'b0;
      r_l_rdata  <= 32'h0000_0000;
    end else begin
      r_f_rvalid <= w_f_gnt;
      r_l_rvalid <= w_l_gnt;
      if (w_f_gnt) begin
        r_f_rdata <= bus.im_rdata;
      end else begin
        r_f_rdata <= r_f_rdata;
      end
      if (w_l_gnt) begin
        // A write reports back the word it stored.
        r_l_rdata <= bus.l_we ? bus.l_wdata : bus.im_rdata;
      end else begin
        r_l_rdata <= r_l_rdata;
      end
    end
  end

`ifdef IM_ARB_RR_EN
  // Track which port was granted most recently (updated on every grant).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_l <= 1'b0;
    end else if (w_l_gnt) begin
      r_last_l <= 1'b1;
    end else if (w_f_gnt) begin
      r_last_l <= 1'b0;
    end else begin
      r_last_l <= r_last_l;
    end
  end
`endif

  assign bus.f_rvalid = r_f_rvalid;
  assign bus.f_rdata  = r_f_rdata;
  assign bus.l_rvalid = r_l_rvalid;
  assign bus.l_rdata  = r_l_rdata;

endmodule

// File: tb/tb_im_arbiter.sv
// ---------------------------------------------------------------------------
// tb_im_arbiter
//
// Directed bench for im_arbiter. A behavioural instruction memory (combinational
// read, write on the rising edge when im_we) sits on the memory port. Inputs
// are driven 1 time unit after the rising edge, combinational outputs are
// checked 1 unit later, registered outputs are checked after the next edge.
// ---------------------------------------------------------------------------
module tb_im_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [31:0] mem [0:1023];

  im_arbiter_if bus ();

  im_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural instruction memory.
  assign bus.im_rdata = mem[bus.im_addr];
  always @(posedge clk) begin
    if (bus.im_we) begin
      mem[bus.im_addr] <= bus.im_wdata;
    end
  end

  // Count one comparison and report it if it differs.
  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %08h expected %08h", tag, act, exp);
    end
  endtask

  // Advance to 1 unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.f_req   = 1'b0;
    bus.f_addr  = 10'h000;
    bus.l_req   = 1'b0;
    bus.l_we    = 1'b0;
    bus.l_addr  = 10'h000;
    bus.l_wdata = 32'h0000_0000;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  logic exp_l [0:3];

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'h1000_0000 | i;
    end
    mem[4] = 32'h2408_000A;
    idle_inputs();
    rst_n = 1'b0;
    step();

    // ---- Reset state and forced-off grants ----
    bus.l_req = 1'b1;
    bus.l_we  = 1'b1;
    bus.l_addr = 10'h011;
    #1;
    chk_val("rst_l_gnt", bus.l_gnt, 32'd0);
    chk_val("rst_im_we", bus.im_we, 32'd0);
    idle_inputs();
    bus.f_req  = 1'b1;
    bus.f_addr = 10'h005;
    #1;
    chk_val("rst_f_gnt", bus.f_gnt, 32'd0);
    chk_val("rst_im_addr", bus.im_addr, 32'h005);
    chk_val("rst_f_rvalid", bus.f_rvalid, 32'd0);
    chk_val("rst_l_rvalid", bus.l_rvalid, 32'd0);
    chk_val("rst_f_rdata", bus.f_rdata, 32'd0);
    chk_val("rst_l_rdata", bus.l_rdata, 32'd0);
    step();
    chk_val("rst_no_f_rvalid", bus.f_rvalid, 32'd0);
    idle_inputs();
    rst_n = 1'b1;

    // ---- Fetch only (first edge after reset is a normal cycle) ----
    bus.f_req  = 1'b1;
    bus.f_addr = 10'h004;
    #1;
    chk_val("fo_f_gnt", bus.f_gnt, 32'd1);
    chk_val("fo_l_gnt", bus.l_gnt, 32'd0);
    chk_val("fo_im_addr", bus.im_addr, 32'h004);
    step();
    bus.f_req = 1'b0;
    chk_val("fo_f_rvalid", bus.f_rvalid, 32'd1);
    chk_val("fo_f_rdata", bus.f_rdata, 32'h2408_000A);
    chk_val("fo_l_rvalid", bus.l_rvalid, 32'd0);
    step();
    chk_val("fo_f_rvalid_off", bus.f_rvalid, 32'd0);
    chk_val("fo_f_rdata_hold", bus.f_rdata, 32'h2408_000A);

    // ---- Loader write then fetch of the same address ----
    bus.l_req   = 1'b1;
    bus.l_we    = 1'b1;
    bus.l_addr  = 10'h010;
    bus.l_wdata = 32'hDEAD_BEEF;
    #1;
    chk_val("wr_l_gnt", bus.l_gnt, 32'd1);
    chk_val("wr_im_we", bus.im_we, 32'd1);
    chk_val("wr_im_addr", bus.im_addr, 32'h010);
    chk_val("wr_im_wdata", bus.im_wdata, 32'hDEAD_BEEF);
    step();
    bus.l_req  = 1'b0;
    bus.l_we   = 1'b0;
    bus.f_req  = 1'b1;
    bus.f_addr = 10'h010;
    #1;
    chk_val("wr_l_rvalid", bus.l_rvalid, 32'd1);
    chk_val("wr_l_rdata", bus.l_rdata, 32'hDEAD_BEEF);
    chk_val("wr_im_we_off", bus.im_we, 32'd0);
    chk_val("wr_f_gnt", bus.f_gnt, 32'd1);
    step();
    bus.f_req = 1'b0;
    chk_val("wr_f_rvalid", bus.f_rvalid, 32'd1);
    chk_val("wr_f_rdata", bus.f_rdata, 32'hDEAD_BEEF);
    chk_val("wr_l_rvalid_off", bus.l_rvalid, 32'd0);
    chk_val("wr_l_rdata_hold", bus.l_rdata, 32'hDEAD_BEEF);

    // ---- Contention ----
    pulse_reset();
    bus.f_req  = 1'b1;
    bus.f_addr = 10'h020;
    bus.l_req  = 1'b1;
    bus.l_we   = 1'b0;
    bus.l_addr = 10'h030;
`ifdef IM_ARB_RR_EN
    exp_l[0] = 1'b1;
    exp_l[1] = 1'b0;
    exp_l[2] = 1'b1;
    exp_l[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_val("rr_l_gnt", bus.l_gnt, {31'd0, exp_l[k]});
      chk_val("rr_f_gnt", bus.f_gnt, {31'd0, ~exp_l[k]});
      if (k > 0) begin
        chk_val("rr_l_rvalid", bus.l_rvalid, {31'd0, exp_l[k-1]});
        chk_val("rr_f_rvalid", bus.f_rvalid, {31'd0, ~exp_l[k-1]});
      end
      step();
    end
    idle_inputs();
    chk_val("rr_l_rvalid_last", bus.l_rvalid, {31'd0, exp_l[3]});
    chk_val("rr_f_rvalid_last", bus.f_rvalid, {31'd0, ~exp_l[3]});
    chk_val("rr_f_rdata", bus.f_rdata, 32'h1000_0020);
    chk_val("rr_l_rdata", bus.l_rdata, 32'h1000_0030);
`else
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_val("fp_l_gnt", bus.l_gnt, 32'd1);
      chk_val("fp_f_gnt", bus.f_gnt, 32'd0);
      chk_val("fp_im_addr", bus.im_addr, 32'h030);
      if (k > 0) begin
        chk_val("fp_l_rvalid", bus.l_rvalid, 32'd1);
        chk_val("fp_l_rdata", bus.l_rdata, 32'h1000_0030);
      end
      step();
    end
    bus.l_req = 1'b0;
    #1;
    chk_val("fp_f_gnt_after", bus.f_gnt, 32'd1);
    chk_val("fp_im_addr_after", bus.im_addr, 32'h020);
    chk_val("fp_l_rvalid_tail", bus.l_rvalid, 32'd1);
    step();
    idle_inputs();
    chk_val("fp_f_rvalid", bus.f_rvalid, 32'd1);
    chk_val("fp_f_rdata", bus.f_rdata, 32'h1000_0020);
    chk_val("fp_l_rvalid_off", bus.l_rvalid, 32'd0);
`endif
    step();

    // ---- Reset in the cycle after a fetch grant ----
    pulse_reset();
    bus.f_req  = 1'b1;
    bus.f_addr = 10'h008;
    #1;
    chk_val("rm_f_gnt", bus.f_gnt, 32'd1);
    step();
    rst_n = 1'b0;
    #1;
    chk_val("rm_f_rvalid", bus.f_rvalid, 32'd0);
    chk_val("rm_f_rdata", bus.f_rdata, 32'd0);
    chk_val("rm_f_gnt_low", bus.f_gnt, 32'd0);
    step();
    chk_val("rm_f_rvalid2", bus.f_rvalid, 32'd0);
    chk_val("rm_f_gnt_low2", bus.f_gnt, 32'd0);
    rst_n = 1'b1;
    bus.f_addr = 10'h009;
    #1;
    chk_val("rm_f_gnt_post", bus.f_gnt, 32'd1);
    step();
    bus.f_req = 1'b0;
    chk_val("rm_f_rvalid_post", bus.f_rvalid, 32'd1);
    chk_val("rm_f_rdata_post", bus.f_rdata, 32'h1000_0009);
    step();

    // ---- Idle: no requests ----
    for (int i = 0; i < 5; i++) begin
      bus.f_addr = 10'h100 + 10'(i * 3);
      #1;
      chk_val("id_f_gnt", bus.f_gnt, 32'd0);
      chk_val("id_l_gnt", bus.l_gnt, 32'd0);
      chk_val("id_im_we", bus.im_we, 32'd0);
      chk_val("id_im_addr", bus.im_addr, 32'h100 + 32'(i * 3));
      chk_val("id_f_rvalid", bus.f_rvalid, 32'd0);
      chk_val("id_l_rvalid", bus.l_rvalid, 32'd0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
